mac_vec_acc: RTL and testbench

MAC_VEC_ACC -- requirements
Module: mac_vec_acc

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_lane.sv | 36 +++
 rtl/mac_vec_acc.sv | 180 ++++++++++++++++++
 tb/tb_mac_vec_acc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the vector multiply-accumulate block.
// Holds the accumulator FSM state encoding and the result-count width.
package mac_pkg;

   localparam int unsigned BwDef     = 4;
   localparam int unsigned PsumBwDef = 16;
   localparam int unsigned ColDef    = 4;
   localparam int unsigned CntW      = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_HOLD
   } state_e;

endpackage

// File: rtl/mac_lane.sv
// One lane of the product stage.
// Multiplies an unsigned activation by a signed weight and registers the result.
module mac_lane
   import mac_pkg::*;
#(
   parameter int unsigned bw = BwDef
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_i,
   input  logic [bw-1:0] a_i,
   input  logic [bw-1:0] b_i,
   output logic [2*bw:0] prod_o
);

   logic [2*bw:0] a_ext;
   logic [2*bw:0] b_ext;
   logic [2*bw:0] prod_d;
   logic [2*bw:0] prod_q;

   // Activation is zero-extended, weight sign-extended, to the full product width.
   assign a_ext  = {{(bw + 1){1'b0}}, a_i};
   assign b_ext  = {{(bw + 1){b_i[bw-1]}}, b_i};
   assign prod_d = $signed(a_ext) * $signed(b_ext);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prod_q <= '0;
      end else if (en_i) begin
         prod_q <= prod_d;
      end
   end

   assign prod_o = prod_q;

endmodule

// File: rtl/mac_vec_acc.sv
// Vector multiply-accumulate: col lanes per beat, summed and accumulated over a vector,
// with a two-stage pipeline, valid/ready handshakes and optional saturation.
module mac_vec_acc
   import mac_pkg::*;
#(
   parameter int unsigned bw      = BwDef,
   parameter int unsigned psum_bw = PsumBwDef,
   parameter int unsigned col     = ColDef,
   parameter bit          sat_en  = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [col*bw-1:0]  a,
   input  logic [col*bw-1:0]  b,
   input  logic               acc_clr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [psum_bw-1:0] out,
   output logic               out_ovf,
   output logic [CntW-1:0]    out_cnt
);

   localparam int unsigned ProdW = 2 * bw + 1;
   localparam int unsigned SumW  = ProdW + $clog2(col);
   localparam logic [psum_bw-1:0] PosMax = {1'b0, {(psum_bw - 1){1'b1}}};
   localparam logic [psum_bw-1:0] NegMin = {1'b1, {(psum_bw - 1){1'b0}}};

   logic [ProdW-1:0] prod [col];

   logic stall, accept, fire, vec_open;
   logic s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
   logic open_d, open_q;
   state_e state_d, state_q;

   logic [psum_bw-1:0] acc_d, acc_q;
   logic [CntW-1:0]    cnt_d, cnt_q;
   logic               ovf_d, ovf_q;
   logic               out_valid_d, out_valid_q;
   logic [psum_bw-1:0] out_d, out_q;
   logic               out_ovf_d, out_ovf_q;
   logic [CntW-1:0]    out_cnt_d, out_cnt_q;

   logic signed [SumW-1:0]    lane_sum;
   logic signed [psum_bw-1:0] sum_ext;
   logic [psum_bw-1:0]        base;
   logic [psum_bw:0]          acc_wide;
   logic                      step_ovf;
   logic [psum_bw-1:0]        acc_new;
   logic                      ovf_new;
   logic [CntW-1:0]           cnt_new;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = reset & ~stall & ~acc_clr;
   assign accept   = in_valid & in_ready;
   assign fire     = s1_valid_q & ~stall & ~acc_clr;

   for (genvar k = 0; k < col; k++) begin : g_lane
      mac_lane #(
         .bw(bw)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .en_i  (accept),
         .a_i   (a[k*bw +: bw]),
         .b_i   (b[k*bw +: bw]),
         .prod_o(prod[k])
      );
   end

   always_comb begin
      lane_sum = '0;
      for (int unsigned k = 0; k < col; k++) begin
         lane_sum = lane_sum + SumW'($signed(prod[k]));
      end
   end

   // A beat that opens a vector adds to zero, never to whatever acc_q still holds.
   assign sum_ext  = psum_bw'(lane_sum);
   assign base     = vec_open ? acc_q : '0;
   assign acc_wide = {base[psum_bw-1], base} + {sum_ext[psum_bw-1], sum_ext};
   assign step_ovf = acc_wide[psum_bw] ^ acc_wide[psum_bw-1];
   assign ovf_new  = (vec_open & ovf_q) | step_ovf;
   assign cnt_new  = !vec_open ? CntW'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + CntW'(1));

   always_comb begin
      acc_new = acc_wide[psum_bw-1:0];
      if (sat_en && step_ovf) begin
         acc_new = acc_wide[psum_bw] ? NegMin : PosMax;
      end
   end

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_d       = out_q;
      out_ovf_d   = out_ovf_q;
      out_cnt_d   = out_cnt_q;
      out_valid_d = out_valid_q & ~out_ready;
      s1_last_d   = accept ? in_last : s1_last_q;
      s1_valid_d  = acc_clr ? 1'b0 : (stall ? s1_valid_q : accept);
      if (acc_clr) begin
         acc_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (fire) begin
         if (s1_last_q) begin
            out_valid_d = 1'b1;
            out_d       = acc_new;
            out_ovf_d   = ovf_new;
            out_cnt_d   = cnt_new;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
         end else begin
            acc_d = acc_new;
            cnt_d = cnt_new;
            ovf_d = ovf_new;
         end
      end
   end

   // open_q remembers whether a vector was open while parked in S_HOLD.
   assign vec_open = (state_q == S_ACC) || ((state_q == S_HOLD) && open_q);

   always_comb begin
      open_d = vec_open;
      if (acc_clr) begin
         open_d = 1'b0;
      end else if (fire) begin
         open_d = ~s1_last_q;
      end
      if (acc_clr) begin
         state_d = S_IDLE;
      end else if (stall) begin
         state_d = S_HOLD;
      end else if (open_d) begin
         state_d = S_ACC;
      end else begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         open_q      <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         out_ovf_q   <= 1'b0;
         out_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         open_q      <= open_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         out_ovf_q   <= out_ovf_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign out_ovf   = out_ovf_q;
   assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_mac_vec_acc.sv
// Bench for mac_vec_acc: a wrapping and a saturating instance share stimulus,
// each result is checked against an arithmetic model of the vector sums.
module tb_mac_vec_acc;

   localparam int unsigned Bw     = 4;
   localparam int unsigned PsumBw = 16;
   localparam int unsigned Col    = 4;

   logic              clk       = 1'b0;
   logic              reset     = 1'b0;
   logic              in_valid  = 1'b0;
   logic              in_last   = 1'b0;
   logic              acc_clr   = 1'b0;
   logic              out_ready = 1'b1;
   logic [Col*Bw-1:0] a         = '0;
   logic [Col*Bw-1:0] b         = '0;

   logic              in_ready_w, out_valid_w, ovf_w;
   logic [PsumBw-1:0] out_w;
   logic [7:0]        cnt_w;
   logic              in_ready_s, out_valid_s, ovf_s;
   logic [PsumBw-1:0] out_s;
   logic [7:0]        cnt_s;

   always #5 clk = ~clk;

   mac_vec_acc #(.bw(Bw), .psum_bw(PsumBw), .col(Col), .sat_en(1'b0)) u_dut_w (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w), .in_last(in_last),
      .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid_w), .out_ready(out_ready),
      .out(out_w), .out_ovf(ovf_w), .out_cnt(cnt_w)
   );

   mac_vec_acc #(.bw(Bw), .psum_bw(PsumBw), .col(Col), .sat_en(1'b1)) u_dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
      .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid_s), .out_ready(out_ready),
      .out(out_s), .out_ovf(ovf_s), .out_cnt(cnt_s)
   );

   typedef struct {
      logic [15:0] out_w;
      logic [15:0] out_s;
      logic        ovf_w;
      logic        ovf_s;
      logic [7:0]  cnt;
   } exp_t;

   exp_t expq[$];
   int   cur[$];
   int   checks = 0;
   int   errors = 0;
   bit   accepted;
   bit   rdy_seen;
   int   tries;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int beat_sum(input logic [Col*Bw-1:0] av, input logic [Col*Bw-1:0] bv);
      int s = 0;
      for (int k = 0; k < Col; k++) begin
         s += int'(av[k*Bw +: Bw]) * int'($signed(bv[k*Bw +: Bw]));
      end
      return s;
   endfunction

   function automatic exp_t close_vec();
      exp_t e;
      int   aw = 0;
      int   as = 0;
      int   t;
      bit   ow = 1'b0;
      bit   os = 1'b0;
      foreach (cur[i]) begin
         t = aw + cur[i];
         if (t > 32767 || t < -32768) ow = 1'b1;
         aw = int'($signed(t[15:0]));
         t = as + cur[i];
         if (t > 32767) begin
            os = 1'b1;
            as = 32767;
         end else if (t < -32768) begin
            os = 1'b1;
            as = -32768;
         end else begin
            as = t;
         end
      end
      e.out_w = aw[15:0];
      e.out_s = as[15:0];
      e.ovf_w = ow;
      e.ovf_s = os;
      e.cnt   = (cur.size() > 255) ? 8'd255 : 8'(cur.size());
      return e;
   endfunction

   // One clock: sample and check at the falling edge, update the model, step past the rise.
   task automatic cycle();
      @(negedge clk);
      rdy_seen = in_ready_w;
      accepted = in_valid && in_ready_w;
      chk("valid_sync", 32'(out_valid_s), 32'(out_valid_w));
      if (out_valid_w) begin
         if (expq.size() == 0) begin
            chk("spurious_out", 32'(out_valid_w), 32'(0));
         end else begin
            chk("out_wrap", 32'(out_w), 32'(expq[0].out_w));
            chk("ovf_wrap", 32'(ovf_w), 32'(expq[0].ovf_w));
            chk("out_sat", 32'(out_s), 32'(expq[0].out_s));
            chk("ovf_sat", 32'(ovf_s), 32'(expq[0].ovf_s));
            chk("cnt_wrap", 32'(cnt_w), 32'(expq[0].cnt));
            chk("cnt_sat", 32'(cnt_s), 32'(expq[0].cnt));
            if (out_ready) void'(expq.pop_front());
         end
      end
      if (acc_clr) cur.delete();
      if (accepted) begin
         cur.push_back(beat_sum(a, b));
         if (in_last) begin
            expq.push_back(close_vec());
            cur.delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic last);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      in_last  = last;
      tries    = 0;
      do begin
         cycle();
         tries++;
      end while (!accepted && tries < 100);
      chk("send_accept", 32'(accepted), 32'(1));
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      while (expq.size() != 0 && n < 40) begin
         cycle();
         n++;
      end
      repeat (3) cycle();
      chk("drain_empty", 32'(expq.size()), 32'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state, with a beat offered while reset is low.
      in_valid = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready_w), 32'(0));
      chk("rst_out_valid", 32'(out_valid_w), 32'(0));
      chk("rst_out", 32'(out_s), 32'(0));
      chk("rst_cnt", 32'(cnt_w), 32'(0));
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;

      // Three beats of 15 * -8 on every lane.
      send(16'hFFFF, 16'h8888, 1'b0);
      send(16'hFFFF, 16'h8888, 1'b0);
      send(16'hFFFF, 16'h8888, 1'b1);
      chk("lat_early", 32'(out_valid_w), 32'(0));
      cycle();
      chk("lat_valid", 32'(out_valid_w), 32'(1));
      chk("neg_out", 32'(out_w), 32'(16'hFA60));
      chk("neg_cnt", 32'(cnt_w), 32'(3));
      chk("neg_ovf", 32'(ovf_w), 32'(0));
      cycle();
      chk("single_out", 32'(expq.size()), 32'(0));
      drain();

      // 79 beats of 15 * 7: overflows, wrapping vs clamping.
      for (int i = 0; i < 79; i++) send(16'hFFFF, 16'h7777, (i == 78));
      cycle();
      chk("sat_out", 32'(out_s), 32'(16'h7FFF));
      chk("sat_ovf", 32'(ovf_s), 32'(1));
      chk("sat_cnt", 32'(cnt_s), 32'(79));
      chk("wrap_out", 32'(out_w), 32'(16'h819C));
      chk("wrap_ovf", 32'(ovf_w), 32'(1));
      drain();

      // Single-beat vectors on consecutive cycles.
      for (int k = 1; k <= 8; k++) begin
         logic [3:0] kb;
         kb       = 4'(k);
         in_valid = 1'b1;
         in_last  = 1'b1;
         a        = 16'h1111;
         b        = {kb, kb, kb, kb};
         cycle();
         chk("b2b_ready", 32'(rdy_seen), 32'(1));
         if (k >= 2) begin
            chk("b2b_valid", 32'(out_valid_w), 32'(1));
            chk("b2b_out", 32'(out_w), 32'(4 * (k - 1)));
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      drain();

      // Result held for 5 cycles with a beat of the next vector in flight.
      out_ready = 1'b0;
      send(16'h3333, 16'h2222, 1'b1);
      send(16'h5A3C, 16'h9F17, 1'b0);
      in_valid = 1'b1;
      in_last  = 1'b1;
      a        = 16'hC0DE;
      b        = 16'h7A21;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_ready", 32'(rdy_seen), 32'(0));
         chk("stall_out", 32'(out_w), 32'(24));
      end
      out_ready = 1'b1;
      send(16'hC0DE, 16'h7A21, 1'b1);
      drain();

      // Clear after two beats, and a beat offered during the clear is refused.
      send(16'h7777, 16'h5555, 1'b0);
      send(16'h9999, 16'h3333, 1'b0);
      acc_clr = 1'b1;
      cycle();
      chk("clr_ready", 32'(rdy_seen), 32'(0));
      in_valid = 1'b1;
      a        = 16'hFFFF;
      b        = 16'h7777;
      cycle();
      chk("clr_no_accept", 32'(accepted), 32'(0));
      in_valid = 1'b0;
      acc_clr  = 1'b0;
      send(16'h2222, 16'h3333, 1'b1);
      cycle();
      chk("clr_out", 32'(out_w), 32'(24));
      chk("clr_cnt", 32'(cnt_w), 32'(1));
      drain();

      // Reset mid-vector with a result pending.
      out_ready = 1'b0;
      send(16'h1111, 16'h1111, 1'b1);
      send(16'h2222, 16'h1111, 1'b0);
      chk("pre_rst_valid", 32'(out_valid_w), 32'(1));
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid_w), 32'(0));
      chk("arst_out", 32'(out_w), 32'(0));
      chk("arst_cnt", 32'(cnt_w), 32'(0));
      chk("arst_ovf_s", 32'(ovf_s), 32'(0));
      chk("arst_out_s", 32'(out_s), 32'(0));
      chk("arst_ready", 32'(in_ready_w), 32'(0));
      expq.delete();
      cur.delete();
      @(posedge clk);
      #3 reset  = 1'b1;
      out_ready = 1'b1;
      send(16'h1111, 16'h1111, 1'b1);
      chk("post_rst_first", 32'(tries), 32'(1));
      repeat (2) cycle();
      drain();

      // Random traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_last   = ($urandom_range(3) == 0);
         out_ready = ($urandom_range(3) != 0);
         a         = 16'($urandom);
         b         = 16'($urandom);
         cycle();
      end
      out_ready = 1'b1;
      send(16'($urandom), 16'($urandom), 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
